sel_accum_loop: RTL and testbench

SEL_ACCUM_LOOP -- requirements
Module: sel_accum_loop

---
 rtl/sel_accum_pkg.sv | 17 +
 rtl/sel_accum_loop_sat_add.sv | 26 ++
 rtl/sel_accum_loop.sv | 123 ++++++++++++
 tb/tb_sel_accum_loop.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sel_accum_pkg.sv
// Shared types and constants for the selectable-increment accumulation loop.
package sel_accum_pkg;

    // Loop controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Selector codes choosing the per-iteration increment.
    localparam logic [1:0] SEL_ZERO = 2'b00;
    localparam logic [1:0] SEL_ONE  = 2'b01;
    localparam logic [1:0] SEL_TWO  = 2'b10;
    localparam logic [1:0] SEL_STEP = 2'b11;

endpackage

// File: rtl/sel_accum_loop_sat_add.sv
// Combinational WIDTH-bit adder with carry-out overflow detection and
// optional saturation to the all-ones value.
module sat_add #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sat_en,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

    logic [WIDTH:0] sum_full;

    // One extra bit holds the carry; a carry out is an overflow.
    always_comb begin
        sum_full = {1'b0, a} + {1'b0, b};
        ovf      = sum_full[WIDTH];
        if (ovf && sat_en) begin
            sum = '1;
        end else begin
            sum = sum_full[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/sel_accum_loop.sv
// Bounded loop that accumulates a selector-chosen increment into sn for
// BOUND iterations, with wrap or saturate arithmetic and a sticky overflow.
// Handshake: a one-cycle start (or held start) begins a run from IDLE/DONE and
// restarts it from RUN; busy is high while iterating, done is high once the
// run completes and stays high until the next start or rst.
module sel_accum_loop
    import sel_accum_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BOUND = 8,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       selector,
    input  logic             sat_en,
    output logic [WIDTH-1:0] sn,
    output logic [WIDTH-1:0] i,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output state_t           dbg_state
);

    // Reject parameter values outside the supported range at elaboration.
    if (BOUND < 1 || BOUND > (1 << WIDTH) - 1) begin : g_bad_bound
        $error("sel_accum_loop: BOUND out of range 1..2^WIDTH-1");
    end
    if (STEP < 0 || STEP > (1 << WIDTH) - 1) begin : g_bad_step
        $error("sel_accum_loop: STEP out of range 0..2^WIDTH-1");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] i_q, i_d;
    logic [WIDTH-1:0] sn_q, sn_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] inc;
    logic [WIDTH-1:0] add_sum;
    logic             add_ovf;

    // Decode the increment for the current iteration.
    always_comb begin
        inc = '0;
        case (selector)
            SEL_ZERO: inc = '0;
            SEL_ONE:  inc = WIDTH'(1);
            SEL_TWO:  inc = WIDTH'(2);
            SEL_STEP: inc = WIDTH'(STEP);
            default:  inc = '0;
        endcase
    end

    sat_add #(
        .WIDTH (WIDTH)
    ) u_sat_add (
        .a      (sn_q),
        .b      (inc),
        .sat_en (sat_en),
        .sum    (add_sum),
        .ovf    (add_ovf)
    );

    // Next-state and datapath updates for the loop controller.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        sn_d    = sn_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    i_d     = '0;
                    sn_d    = '0;
                    ovf_d   = 1'b0;
                end
            end
            RUN: begin
                if (start) begin
                    // Restart edge: clear and do not accumulate.
                    i_d   = '0;
                    sn_d  = '0;
                    ovf_d = 1'b0;
                end else begin
                    i_d   = i_q + WIDTH'(1);
                    sn_d  = add_sum;
                    ovf_d = ovf_q | add_ovf;
                    if (i_q == WIDTH'(BOUND - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            sn_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            sn_q    <= sn_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sn        = sn_q;
    assign i         = i_q;
    assign ovf       = ovf_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sel_accum_loop.sv
// Bench for sel_accum_loop: two instances (8-bit and 4-bit configurations)
// driven with directed and randomized runs; expected run results are queued
// at issue time and checked by monitors when done rises.
module tb_sel_accum_loop;
    import sel_accum_pkg::*;

    localparam int A_W = 8;
    localparam int A_B = 8;
    localparam int A_S = 4;
    localparam int B_W = 4;
    localparam int B_B = 15;
    localparam int B_S = 3;

    // Clock and reset.
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           a_start = 1'b0, b_start = 1'b0;
    logic [1:0]     a_sel = 2'b00, b_sel = 2'b00;
    logic           a_sat = 1'b0, b_sat = 1'b0;
    logic [A_W-1:0] a_sn, a_i;
    logic [B_W-1:0] b_sn, b_i;
    logic           a_busy, a_done, a_ovf, b_busy, b_done, b_ovf;
    state_t         a_state, b_state;

    sel_accum_loop #(.WIDTH(A_W), .BOUND(A_B), .STEP(A_S)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .selector(a_sel), .sat_en(a_sat),
        .sn(a_sn), .i(a_i), .busy(a_busy), .done(a_done), .ovf(a_ovf),
        .dbg_state(a_state)
    );

    sel_accum_loop #(.WIDTH(B_W), .BOUND(B_B), .STEP(B_S)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .selector(b_sel), .sat_en(b_sat),
        .sn(b_sn), .i(b_i), .busy(b_busy), .done(b_done), .ovf(b_ovf),
        .dbg_state(b_state)
    );

    // Scoreboard: expected {ovf, i, sn} at completion of each run.
    logic [A_W*2:0] exp_qa[$];
    logic [B_W*2:0] exp_qb[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] obs_i(input int which);
        return (which == 0) ? 32'(a_i) : 32'(b_i);
    endfunction
    function automatic logic [31:0] obs_sn(input int which);
        return (which == 0) ? 32'(a_sn) : 32'(b_sn);
    endfunction
    function automatic logic [31:0] obs_ovf(input int which);
        return (which == 0) ? 32'(a_ovf) : 32'(b_ovf);
    endfunction
    function automatic logic [31:0] obs_busy(input int which);
        return (which == 0) ? 32'(a_busy) : 32'(b_busy);
    endfunction
    function automatic logic [31:0] obs_done(input int which);
        return (which == 0) ? 32'(a_done) : 32'(b_done);
    endfunction

    // Drivers.
    task automatic drive(input int which, input logic st, input logic [1:0] s, input logic t);
        if (which == 0) begin
            a_start = st; a_sel = s; a_sat = t;
        end else begin
            b_start = st; b_sel = s; b_sat = t;
        end
    endtask

    // Start a run and let it iterate n edges, without queuing a result.
    task automatic partial_run(input int which, input int n);
        drive(which, 1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        @(posedge clk); #1;
        drive(which, 1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        repeat (n) begin
            @(posedge clk); #1;
        end
        chk("partial_i", obs_i(which), 32'(n));
        chk("partial_busy", obs_busy(which), 32'd1);
    endtask

    // Full run; sel_mode/sat_mode of -1 means random per iteration.
    task automatic do_run(input int which, input int sel_mode, input int sat_mode);
        int bound, maxv, stp, acc, ov, inc, sum;
        int sels[$];
        int sats[$];
        bound = (which == 0) ? A_B : B_B;
        maxv  = (which == 0) ? (1 << A_W) - 1 : (1 << B_W) - 1;
        stp   = (which == 0) ? A_S : B_S;
        acc = 0;
        ov  = 0;
        for (int k = 0; k < bound; k++) begin
            int s, t;
            s = (sel_mode < 0) ? int'($urandom_range(0, 3)) : sel_mode;
            t = (sat_mode < 0) ? int'($urandom_range(0, 1)) : sat_mode;
            sels.push_back(s);
            sats.push_back(t);
            inc = (s == 0) ? 0 : (s == 1) ? 1 : (s == 2) ? 2 : stp;
            sum = acc + inc;
            if (sum > maxv) begin
                ov  = 1;
                acc = (t != 0) ? maxv : sum - (maxv + 1);
            end else begin
                acc = sum;
            end
        end
        if (which == 0) exp_qa.push_back({1'(ov), 8'(bound), 8'(acc)});
        else            exp_qb.push_back({1'(ov), 4'(bound), 4'(acc)});

        drive(which, 1'b1, 2'(sels[0]), 1'(sats[0]));
        @(posedge clk); #1;
        drive(which, 1'b0, 2'(sels[0]), 1'(sats[0]));
        @(negedge clk);
        chk("start_i", obs_i(which), 32'd0);
        chk("start_sn", obs_sn(which), 32'd0);
        chk("start_ovf", obs_ovf(which), 32'd0);
        chk("start_busy", obs_busy(which), 32'd1);
        for (int k = 0; k < bound; k++) begin
            drive(which, 1'b0, 2'(sels[k]), 1'(sats[k]));
            @(posedge clk); #1;
            if (k < bound - 1) begin
                chk("run_busy", obs_busy(which), 32'd1);
                chk("run_done", obs_done(which), 32'd0);
            end
        end
        chk("end_done", obs_done(which), 32'd1);
        chk("end_busy", obs_busy(which), 32'd0);
    endtask

    // Monitors: compare on each rising done.
    logic a_done_prev = 1'b0;
    logic b_done_prev = 1'b0;
    always @(negedge clk) begin
        logic [A_W*2:0] ea;
        logic [B_W*2:0] eb;
        if (a_done && !a_done_prev) begin
            if (exp_qa.size() == 0) begin
                chk("a_unexpected_done", 32'd1, 32'd0);
            end else begin
                ea = exp_qa.pop_front();
                chk("a_ovf", 32'(a_ovf), 32'(ea[16]));
                chk("a_i", 32'(a_i), 32'(ea[15:8]));
                chk("a_sn", 32'(a_sn), 32'(ea[7:0]));
            end
        end
        if (b_done && !b_done_prev) begin
            if (exp_qb.size() == 0) begin
                chk("b_unexpected_done", 32'd1, 32'd0);
            end else begin
                eb = exp_qb.pop_front();
                chk("b_ovf", 32'(b_ovf), 32'(eb[8]));
                chk("b_i", 32'(b_i), 32'(eb[7:4]));
                chk("b_sn", 32'(b_sn), 32'(eb[3:0]));
            end
        end
        a_done_prev <= a_done;
        b_done_prev <= b_done;
    end

    task automatic chk_zero(input string tag, input int which);
        chk({tag, "_i"}, obs_i(which), 32'd0);
        chk({tag, "_sn"}, obs_sn(which), 32'd0);
        chk({tag, "_ovf"}, obs_ovf(which), 32'd0);
        chk({tag, "_busy"}, obs_busy(which), 32'd0);
        chk({tag, "_done"}, obs_done(which), 32'd0);
    endtask

    initial begin
        int lat;
        // Reset.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_zero("rst_a", 0);
        chk_zero("rst_b", 1);
        chk("rst_state", 32'(a_state), 32'(IDLE));

        // IDLE holds while start is low.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("idle_a", 0);

        // Latency: edges from driving start to done visible.
        drive(0, 1'b1, SEL_ONE, 1'b0);
        lat = 0;
        for (int k = 0; k < 40 && !a_done; k++) begin
            @(posedge clk); #1;
            drive(0, 1'b0, SEL_ONE, 1'b0);
            lat++;
        end
        chk("latency", 32'(lat), 32'(A_B + 1));
        chk("lat_i", 32'(a_i), 32'd8);
        chk("lat_sn", 32'(a_sn), 32'd8);
        chk("lat_ovf", 32'(a_ovf), 32'd0);
        a_done_prev = 1'b1;
        // DONE holds for 20 cycles.
        repeat (20) begin
            @(negedge clk);
            chk("hold_i", 32'(a_i), 32'd8);
            chk("hold_sn", 32'(a_sn), 32'd8);
            chk("hold_done", 32'(a_done), 32'd1);
        end

        // Constant selectors; start issued while in DONE.
        do_run(0, 1, 0);
        do_run(0, 3, -1);
        do_run(0, 0, 0);

        // Overflow: saturate then wrap, second run starts from DONE.
        do_run(1, 3, 1);
        do_run(1, 3, 0);

        // Restart mid-run at i=3.
        partial_run(0, 3);
        do_run(0, -1, -1);

        // rst with start during RUN at i=5.
        partial_run(0, 5);
        rst = 1'b1;
        a_start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        a_start = 1'b0;
        @(negedge clk);
        chk_zero("rst_run", 0);
        chk("rst_run_state", 32'(a_state), 32'(IDLE));
        do_run(0, 1, 0);

        // Randomized runs on both configurations.
        repeat (10) begin
            do_run(0, -1, -1);
            do_run(1, -1, -1);
        end

        repeat (3) @(negedge clk);
        chk("a_queue_empty", 32'(exp_qa.size()), 32'd0);
        chk("b_queue_empty", 32'(exp_qb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
